// File: rtl/fb_pkg.sv
// Shared types, default geometry and address math for the colour framebuffer.
package fb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RMW_RD,
    ST_RMW_CAP,
    ST_RMW_WR
  } fb_state_t;

  localparam int FB_RAMLENGTH  = 800;
  localparam int FB_DATA_WIDTH = 6;
  localparam int FB_PIX_H      = 80;
  localparam int FB_PIX_V      = 60;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  bit_idx;
  } fb_addr_bit_t;

  // Row-major pixel index split into word address and bit (bit 0 = leftmost pixel).
  function automatic fb_addr_bit_t pix_to_addr_bit(input logic [15:0] x,
                                                   input logic [15:0] y,
                                                   input int          pix_h,
                                                   input int          data_width);
    fb_addr_bit_t r;
    int           idx;
    idx       = int'(y) * pix_h + int'(x);
    r.addr    = 16'(idx / data_width);
    r.bit_idx = 8'(idx % data_width);
    return r;
  endfunction

endpackage

// File: rtl/fb_access_sequencer_if.sv
// Client-side and RAM-side signals of the framebuffer access sequencer.
interface fb_access_sequencer_if
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(FB_RAMLENGTH),
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int PX_WIDTH   = $clog2(FB_PIX_H),
  parameter int PY_WIDTH   = $clog2(FB_PIX_V)
);
  logic                  disp_req;
  logic [ADDR_WIDTH-1:0] disp_addr;
  logic                  clear_req;
  logic                  clear_busy;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [PX_WIDTH-1:0]   wr_x;
  logic [PY_WIDTH-1:0]   wr_y;
  logic [2:0]            wr_rgb;
  logic                  wr_drop;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic [DATA_WIDTH-1:0] mem_wdata_g;
  logic [DATA_WIDTH-1:0] mem_wdata_b;
  logic [DATA_WIDTH-1:0] mem_q_r;
  logic [DATA_WIDTH-1:0] mem_q_g;
  logic [DATA_WIDTH-1:0] mem_q_b;

  // The sequencer serves requests and drives the RAM port.
  modport slave (
    input  disp_req, disp_addr, clear_req, wr_valid, wr_x, wr_y, wr_rgb,
    input  mem_q_r, mem_q_g, mem_q_b,
    output clear_busy, wr_ready, wr_drop,
    output mem_addr, mem_we, mem_wdata_r, mem_wdata_g, mem_wdata_b
  );

  modport master (
    output disp_req, disp_addr, clear_req, wr_valid, wr_x, wr_y, wr_rgb,
    output mem_q_r, mem_q_g, mem_q_b,
    input  clear_busy, wr_ready, wr_drop,
    input  mem_addr, mem_we, mem_wdata_r, mem_wdata_g, mem_wdata_b
  );

endinterface

// File: rtl/fb_pixel_merge.sv
// Replaces one bit in each of three colour-plane words with the matching rgb bit.
module fb_pixel_merge #(
  parameter int DATA_WIDTH = 6,
  parameter int BIT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] q_r,
  input  logic [DATA_WIDTH-1:0] q_g,
  input  logic [DATA_WIDTH-1:0] q_b,
  input  logic [BIT_WIDTH-1:0]  bit_idx,
  input  logic [2:0]            rgb,
  output logic [DATA_WIDTH-1:0] merged_r,
  output logic [DATA_WIDTH-1:0] merged_g,
  output logic [DATA_WIDTH-1:0] merged_b
);

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      localparam logic [BIT_WIDTH-1:0] SEL = BIT_WIDTH'(gi);
      assign merged_r[gi] = (bit_idx == SEL) ? rgb[2] : q_r[gi];
      assign merged_g[gi] = (bit_idx == SEL) ? rgb[1] : q_g[gi];
      assign merged_b[gi] = (bit_idx == SEL) ? rgb[0] : q_b[gi];
    end
  endgenerate

endmodule

// File: rtl/fb_access_sequencer.sv
// Arbitrates the shared R/G/B framebuffer RAM port between display reads,
// the full-memory clear sequencer and the read-modify-write pixel writer.
module fb_access_sequencer
  import fb_pkg::*;
#(
  parameter int RAMLENGTH  = FB_RAMLENGTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int PIX_H      = FB_PIX_H,
  parameter int PIX_V      = FB_PIX_V,
  parameter int ADDR_WIDTH = $clog2(RAMLENGTH),
  parameter int PX_WIDTH   = $clog2(PIX_H),
  parameter int PY_WIDTH   = $clog2(PIX_V)
) (
  input logic                  clk,
  input logic                  reset,
  fb_access_sequencer_if.slave bus
);

  localparam int BIT_WIDTH = $clog2(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAMLENGTH - 1);

  fb_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] waddr_reg, waddr_next;
  logic [BIT_WIDTH-1:0]  wbit_reg, wbit_next;
  logic [2:0]            rgb_reg, rgb_next;
  logic [DATA_WIDTH-1:0] wd_r_reg, wd_r_next;
  logic [DATA_WIDTH-1:0] wd_g_reg, wd_g_next;
  logic [DATA_WIDTH-1:0] wd_b_reg, wd_b_next;
  logic                  clear_pend_reg, clear_pend_next;
  logic                  wr_drop_reg, wr_drop_next;

  logic [PX_WIDTH-1:0]   wr_x;
  logic [PY_WIDTH-1:0]   wr_y;
  logic                  in_range;
  fb_addr_bit_t          pix_ab;
  logic                  unused_ab_bits;
  logic [DATA_WIDTH-1:0] merged_r, merged_g, merged_b;
  logic [ADDR_WIDTH-1:0] fsm_addr;
  logic                  fsm_we;
  logic                  wr_ready_c;
  logic                  stall;
  logic                  bus_we;

  assign wr_x     = bus.wr_x;
  assign wr_y     = bus.wr_y;
  assign stall    = bus.disp_req;
  assign in_range = (int'(wr_x) < PIX_H) && (int'(wr_y) < PIX_V);
  assign pix_ab   = pix_to_addr_bit(16'(wr_x), 16'(wr_y), PIX_H, DATA_WIDTH);
  assign unused_ab_bits = ^{pix_ab.addr[15:ADDR_WIDTH], pix_ab.bit_idx[7:BIT_WIDTH]};

  fb_pixel_merge #(
    .DATA_WIDTH(DATA_WIDTH),
    .BIT_WIDTH (BIT_WIDTH)
  ) u_merge (
    .q_r     (bus.mem_q_r),
    .q_g     (bus.mem_q_g),
    .q_b     (bus.mem_q_b),
    .bit_idx (wbit_reg),
    .rgb     (rgb_reg),
    .merged_r(merged_r),
    .merged_g(merged_g),
    .merged_b(merged_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      waddr_reg      <= '0;
      wbit_reg       <= '0;
      rgb_reg        <= '0;
      wd_r_reg       <= '0;
      wd_g_reg       <= '0;
      wd_b_reg       <= '0;
      clear_pend_reg <= 1'b0;
      wr_drop_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      waddr_reg      <= waddr_next;
      wbit_reg       <= wbit_next;
      rgb_reg        <= rgb_next;
      wd_r_reg       <= wd_r_next;
      wd_g_reg       <= wd_g_next;
      wd_b_reg       <= wd_b_next;
      clear_pend_reg <= clear_pend_next;
      wr_drop_reg    <= wr_drop_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    waddr_next      = waddr_reg;
    wbit_next       = wbit_reg;
    rgb_next        = rgb_reg;
    wd_r_next       = wd_r_reg;
    wd_g_next       = wd_g_reg;
    wd_b_next       = wd_b_reg;
    clear_pend_next = clear_pend_reg;
    wr_drop_next    = 1'b0;
    fsm_addr        = '0;
    fsm_we          = 1'b0;
    wr_ready_c      = 1'b0;

    // A clear request seen mid-write is remembered and served once the write lands.
    if ((state_reg == ST_RMW_RD) || (state_reg == ST_RMW_CAP) || (state_reg == ST_RMW_WR)) begin
      if (bus.clear_req) clear_pend_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        wr_ready_c = !bus.clear_req;
        if (bus.clear_req) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end else if (bus.wr_valid) begin
          if (in_range) begin
            waddr_next = pix_ab.addr[ADDR_WIDTH-1:0];
            wbit_next  = pix_ab.bit_idx[BIT_WIDTH-1:0];
            rgb_next   = bus.wr_rgb;
            state_next = ST_RMW_RD;
          end else begin
            wr_drop_next = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        fsm_addr = cnt_reg;
        fsm_we   = 1'b1;
        if (!stall) begin
          if (cnt_reg == LAST_ADDR) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_RMW_RD: begin
        fsm_addr = waddr_reg;
        if (!stall) state_next = ST_RMW_CAP;
      end
      ST_RMW_CAP: begin
        // Read data belongs to the RMW_RD address whether or not the display owns the bus now.
        wd_r_next  = merged_r;
        wd_g_next  = merged_g;
        wd_b_next  = merged_b;
        state_next = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        fsm_addr = waddr_reg;
        fsm_we   = 1'b1;
        if (!stall) begin
          if (clear_pend_reg || bus.clear_req) begin
            state_next      = ST_CLEAR;
            cnt_next        = '0;
            clear_pend_next = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus_we          = !reset && !stall && fsm_we;
  assign bus.mem_we      = bus_we;
  assign bus.mem_addr    = reset ? '0 : (stall ? bus.disp_addr : fsm_addr);
  assign bus.mem_wdata_r = (bus_we && state_reg == ST_RMW_WR) ? wd_r_reg : '0;
  assign bus.mem_wdata_g = (bus_we && state_reg == ST_RMW_WR) ? wd_g_reg : '0;
  assign bus.mem_wdata_b = (bus_we && state_reg == ST_RMW_WR) ? wd_b_reg : '0;
  assign bus.wr_ready    = wr_ready_c && !reset;
  assign bus.clear_busy  = (state_reg == ST_CLEAR);
  assign bus.wr_drop     = wr_drop_reg;

endmodule

// File: tb/tb_fb_access_sequencer.sv
// Directed bench for fb_access_sequencer with a registered-read RAM model.
module tb_fb_access_sequencer;
  import fb_pkg::*;

  localparam int RL  = 800;
  localparam int DW  = 6;
  localparam int AW  = 10;
  localparam int PXW = 7;
  localparam int PYW = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fb_access_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PX_WIDTH(PXW), .PY_WIDTH(PYW)) bus ();

  fb_access_sequencer #(
    .RAMLENGTH(RL), .DATA_WIDTH(DW), .PIX_H(80), .PIX_V(60),
    .ADDR_WIDTH(AW), .PX_WIDTH(PXW), .PY_WIDTH(PYW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // RAM model plus write bookkeeping
  logic [DW-1:0] ram_r [RL];
  logic [DW-1:0] ram_g [RL];
  logic [DW-1:0] ram_b [RL];
  int            wcount [RL];
  int            total_writes;
  int            viol;
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_r, pre_g, pre_b;
  logic          cnt_clr;

  always @(posedge clk) begin
    if (pre_en) begin
      ram_r[pre_addr] <= pre_r;
      ram_g[pre_addr] <= pre_g;
      ram_b[pre_addr] <= pre_b;
    end else if (bus.mem_we) begin
      ram_r[bus.mem_addr] <= bus.mem_wdata_r;
      ram_g[bus.mem_addr] <= bus.mem_wdata_g;
      ram_b[bus.mem_addr] <= bus.mem_wdata_b;
    end
    if (cnt_clr) begin
      for (int i = 0; i < RL; i++) wcount[i] <= 0;
      total_writes <= 0;
      viol         <= 0;
    end else if (bus.mem_we) begin
      wcount[bus.mem_addr] <= wcount[bus.mem_addr] + 1;
      total_writes         <= total_writes + 1;
      if (bus.disp_req) viol <= viol + 1;
    end
    bus.mem_q_r <= ram_r[bus.mem_addr];
    bus.mem_q_g <= ram_g[bus.mem_addr];
    bus.mem_q_b <= ram_b[bus.mem_addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] r, g, b);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_r = r; pre_g = g; pre_b = b;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  typedef struct {
    logic [PXW-1:0] x;
    logic [PYW-1:0] y;
    logic [2:0]     rgb;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  pr, pg, pb;
    logic [DW-1:0]  er, eg, eb;
    logic           drop;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int busy;
    int bad;
    int nz;
    logic found;

    vecs[0] = '{7'd7,  6'd0,  3'b101, 10'd1,   6'o00, 6'o00, 6'o00, 6'b000010, 6'b000000, 6'b000010, 1'b0};
    vecs[1] = '{7'd79, 6'd0,  3'b000, 10'd13,  6'b111111, 6'b100100, 6'b011001, 6'b111101, 6'b100100, 6'b011001, 1'b0};
    vecs[2] = '{7'd0,  6'd0,  3'b111, 10'd0,   6'o00, 6'o00, 6'o00, 6'b000001, 6'b000001, 6'b000001, 1'b0};
    vecs[3] = '{7'd79, 6'd59, 3'b010, 10'd799, 6'b111111, 6'b000000, 6'b111111, 6'b011111, 6'b100000, 6'b011111, 1'b0};
    vecs[4] = '{7'd5,  6'd3,  3'b100, 10'd40,  6'b000000, 6'b111111, 6'b101010, 6'b100000, 6'b011111, 6'b001010, 1'b0};
    vecs[5] = '{7'd80, 6'd5,  3'b111, 10'd2,   6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 1'b1};
    vecs[6] = '{7'd10, 6'd60, 3'b111, 10'd2,   6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 1'b1};
    vecs[7] = '{7'd127,6'd63, 3'b111, 10'd2,   6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 1'b1};
    vecs[8] = '{7'd13, 6'd1,  3'b011, 10'd15,  6'b001000, 6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b001000, 1'b0};

    reset = 1'b1;
    bus.disp_req = 1'b0; bus.disp_addr = 10'd100; bus.clear_req = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_rgb = '0;
    pre_en = 1'b0; pre_addr = '0; pre_r = '0; pre_g = '0; pre_b = '0; cnt_clr = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_clear_busy", 32'(bus.clear_busy), 0);
    check("rst_wr_ready",   32'(bus.wr_ready), 0);
    check("rst_wr_drop",    32'(bus.wr_drop), 0);
    check("rst_mem_we",     32'(bus.mem_we), 0);
    check("rst_mem_addr",   32'(bus.mem_addr), 0);
    check("rst_wdata",      32'({bus.mem_wdata_r, bus.mem_wdata_g, bus.mem_wdata_b}), 0);
    @(negedge clk);
    reset = 1'b0; cnt_clr = 1'b0;
    #1;
    check("post_rst_wr_ready", 32'(bus.wr_ready), 1);
    preload(10'd100, 6'b111111, 6'b111111, 6'b111111);

    // table-driven single writes
    for (int i = 0; i < 9; i++) begin
      preload(vecs[i].addr, vecs[i].pr, vecs[i].pg, vecs[i].pb);
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      bus.wr_valid = 1'b1; bus.wr_x = vecs[i].x; bus.wr_y = vecs[i].y; bus.wr_rgb = vecs[i].rgb;
      #1;
      check("vec_ready_accept", 32'(bus.wr_ready), 1);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      #1;
      check("vec_drop", 32'(bus.wr_drop), 32'(vecs[i].drop));
      if (vecs[i].drop) check("vec_drop_ready", 32'(bus.wr_ready), 1);
      else              check("vec_busy_ready", 32'(bus.wr_ready), 0);
      @(negedge clk);
      @(negedge clk);
      #1;
      if (!vecs[i].drop) begin
        check("vec_we",   32'(bus.mem_we), 1);
        check("vec_addr", 32'(bus.mem_addr), 32'(vecs[i].addr));
        check("vec_wd_r", 32'(bus.mem_wdata_r), 32'(vecs[i].er));
        check("vec_wd_g", 32'(bus.mem_wdata_g), 32'(vecs[i].eg));
        check("vec_wd_b", 32'(bus.mem_wdata_b), 32'(vecs[i].eb));
      end else begin
        check("vec_drop_no_we", 32'(bus.mem_we), 0);
      end
      @(negedge clk);
      #1;
      check("vec_ready_after", 32'(bus.wr_ready), 1);
      check("vec_drop_single", 32'(bus.wr_drop), 0);
      @(negedge clk);
      #1;
      check("vec_write_count", 32'(total_writes), vecs[i].drop ? 0 : 1);
      $display("vector %0d x=%0d y=%0d rgb=%b drop=%0d", i, vecs[i].x, vecs[i].y, vecs[i].rgb, vecs[i].drop);
    end

    // display holds the bus across RMW_CAP and RMW_WR
    preload(10'd1, 6'o00, 6'o00, 6'o00);
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_x = 7'd7; bus.wr_y = 6'd0; bus.wr_rgb = 3'b101;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    @(negedge clk);
    bus.disp_req = 1'b1;
    #1;
    check("cont_disp_addr", 32'(bus.mem_addr), 100);
    check("cont_cap_we", 32'(bus.mem_we), 0);
    @(negedge clk);
    #1;
    check("cont_wr_stall_we", 32'(bus.mem_we), 0);
    @(negedge clk);
    #1;
    check("cont_wr_stall_we2", 32'(bus.mem_we), 0);
    check("cont_wr_stall_ready", 32'(bus.wr_ready), 0);
    @(negedge clk);
    bus.disp_req = 1'b0;
    #1;
    check("cont_we", 32'(bus.mem_we), 1);
    check("cont_addr", 32'(bus.mem_addr), 1);
    check("cont_wdata", 32'({bus.mem_wdata_r, bus.mem_wdata_g, bus.mem_wdata_b}), 32'({6'b000010, 6'b000000, 6'b000010}));
    @(negedge clk);
    #1;
    check("cont_ready", 32'(bus.wr_ready), 1);
    $display("contended rmw done");

    // clear requested while a write is in flight
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_x = 7'd0; bus.wr_y = 6'd1; bus.wr_rgb = 3'b111;
    @(negedge clk);
    bus.wr_valid = 1'b0; bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    @(negedge clk);
    #1;
    check("pend_rmw_we", 32'(bus.mem_we), 1);
    check("pend_rmw_addr", 32'(bus.mem_addr), 13);
    @(negedge clk);
    #1;
    check("pend_ready", 32'(bus.wr_ready), 0);
    check("pend_busy", 32'(bus.clear_busy), 1);
    check("pend_clear_addr", 32'(bus.mem_addr), 0);
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      #1;
      if (!bus.clear_busy) found = 1'b1;
    end
    check("pend_clear_done", 32'(found), 1);
    check("pend_word13_writes", 32'(wcount[13]), 2);
    check("pend_word13_zero", 32'({ram_r[13], ram_g[13], ram_b[13]}), 0);
    $display("pending clear done");

    // clear with the display taking every other cycle
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0; bus.clear_req = 1'b1;
    #1;
    check("clr_ready_low", 32'(bus.wr_ready), 0);
    busy = 0;
    found = 1'b0;
    for (int k = 1; k < 3000 && !found; k++) begin
      @(negedge clk);
      bus.clear_req = 1'b0;
      bus.disp_req = (k % 2 == 1);
      #1;
      if (bus.clear_busy) busy++;
      else found = 1'b1;
    end
    bus.disp_req = 1'b0;
    check("clr_finished", 32'(found), 1);
    check("clr_busy_len", 32'(busy >= 1599 && busy <= 1601), 1);
    bad = 0;
    nz = 0;
    for (int a = 0; a < RL; a++) begin
      if (wcount[a] != 1) bad++;
      if ({ram_r[a], ram_g[a], ram_b[a]} != 18'd0) nz++;
    end
    check("clr_once_each", 32'(bad), 0);
    check("clr_all_zero", 32'(nz), 0);
    check("clr_total", 32'(total_writes), 800);
    check("clr_no_we_on_disp", 32'(viol), 0);
    $display("clear with display contention busy=%0d", busy);

    // clear wins over a same-cycle write; reset lands mid-clear
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0; bus.clear_req = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_x = 7'd3; bus.wr_y = 6'd0; bus.wr_rgb = 3'b111;
    #1;
    check("tie_ready_low", 32'(bus.wr_ready), 0);
    @(negedge clk);
    bus.clear_req = 1'b0; bus.wr_valid = 1'b0;
    #1;
    check("tie_busy", 32'(bus.clear_busy), 1);
    check("tie_first_addr", 32'(bus.mem_addr), 0);
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(negedge clk);
      #1;
      if (bus.mem_we && bus.mem_addr == 10'd400) found = 1'b1;
    end
    check("tie_reach_400", 32'(found), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.clear_busy), 0);
    check("mid_rst_we", 32'(bus.mem_we), 0);
    check("mid_rst_addr", 32'(bus.mem_addr), 0);
    check("mid_rst_ready", 32'(bus.wr_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("after_rst_ready", 32'(bus.wr_ready), 1);
    check("after_rst_busy", 32'(bus.clear_busy), 0);
    repeat (10) @(negedge clk);
    #1;
    check("after_rst_writes", 32'(total_writes), 400);
    check("after_rst_word400", 32'(wcount[400]), 0);
    check("after_rst_word3", 32'(wcount[0]), 1);
    $display("clear/write tie and reset abort done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
